// File: rtl/relogio_pkg.sv
// relogio_pkg
//   Constants and types shared by the seconds, minutes and hours stages of
//   the clock datapath.
//   SEG_MAX   : last value of a seconds/minutes count (59)
//   SEG_W     : width of a seconds/minutes count (6 bits)
//   tempo_t   : one seconds/minutes value
//   clamp_seg : limits a loaded value to 0..SEG_MAX
package relogio_pkg;

  localparam int SEG_MAX = 59;
  localparam int SEG_W   = 6;

  typedef logic [SEG_W-1:0] tempo_t;

  localparam tempo_t SEG_MAX_T = tempo_t'(SEG_MAX);

  function automatic tempo_t clamp_seg(input tempo_t v);
    return (v > SEG_MAX_T) ? SEG_MAX_T : v;
  endfunction

endpackage

// File: rtl/prescaler.sv
// prescaler
//   Free-running divide-by-DIV counter that flags the last cycle of each
//   period. Also used by the blink/colon-flash logic.
//   clk_i  : system clock, rising edge
//   rstn_i : asynchronous active-low reset
//   en_i   : count enable; low holds the current phase
//   sclr_i : synchronous clear back to phase 0 (overrides en_i)
//   term_o : high when the counter sits on DIV-1 and en_i is high
module prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  input  logic sclr_i,
  output logic term_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] pre_q;

  // With DIV = 1, LAST is 0 and pre_q never leaves 0, so every enabled
  // cycle is terminal.
  assign term_o = en_i && (pre_q == LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_q <= '0;
    end else if (sclr_i) begin
      pre_q <= '0;
    end else if (en_i) begin
      pre_q <= (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/segundos.sv
// segundos
//   Seconds stage of the clock datapath. Divides the system clock to a 1 Hz
//   tick and counts seconds 0..59, emitting a carry pulse on each 59->0 wrap
//   for the minutes counter.
//   clk_i      : system clock, rising edge
//   rstn_i     : asynchronous active-low reset
//   en_i       : run enable; low freezes prescaler and seconds
//   clr_i      : synchronous clear of seconds and prescaler (highest priority)
//   set_i      : synchronous load of set_val_i (clamped to 59)
//   set_val_i  : value to load
//   tick_o     : one-cycle pulse per elapsed second
//   alt_o      : one-cycle carry pulse on the 59->0 wrap
//   segundos_o : current seconds 0..59
module segundos
  import relogio_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [SEG_W-1:0] set_val_i,
  output logic             tick_o,
  output logic             alt_o,
  output logic [SEG_W-1:0] segundos_o
);

  logic   term;
  tempo_t seg_q, seg_d;
  logic   tick_q, tick_d;
  logic   alt_q, alt_d;

  // Any clear or load restarts the second from phase 0.
  prescaler #(
    .DIV (CLK_FREQ)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .en_i   (en_i),
    .sclr_i (clr_i | set_i),
    .term_o (term)
  );

  // clr > set > terminal tick; a tick landing on clr/set is dropped,
  // including its carry.
  always_comb begin
    seg_d  = seg_q;
    tick_d = 1'b0;
    alt_d  = 1'b0;
    if (clr_i) begin
      seg_d = '0;
    end else if (set_i) begin
      seg_d = clamp_seg(set_val_i);
    end else if (term) begin
      tick_d = 1'b1;
      if (seg_q == SEG_MAX_T) begin
        seg_d = '0;
        alt_d = 1'b1;
      end else begin
        seg_d = seg_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seg_q  <= '0;
      tick_q <= 1'b0;
      alt_q  <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      tick_q <= tick_d;
      alt_q  <= alt_d;
    end
  end

  assign segundos_o = seg_q;
  assign tick_o     = tick_q;
  assign alt_o      = alt_q;

endmodule

// File: tb/tb_segundos.sv
module tb_segundos;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       en_i;
  logic       clr_i;
  logic       set_i;
  logic [5:0] set_val_i;
  logic       tick_o;
  logic       alt_o;
  logic [5:0] segundos_o;

  int nvec = 0;
  int nerr = 0;

  segundos #(
    .CLK_FREQ (4)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .set_i      (set_i),
    .set_val_i  (set_val_i),
    .tick_o     (tick_o),
    .alt_o      (alt_o),
    .segundos_o (segundos_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rstn_i = 1'b0; en_i = 1'b1; clr_i = 1'b0; set_i = 1'b0; set_val_i = '0;
    #12;
    got = {tick_o, alt_o, segundos_o};
    nvec++;
    if (got !== 8'h00) begin
      nerr++;
      $display("FAIL reset {tick,alt,seg} got %h want %h", got, 8'h00);
    end
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
  endtask

  // Scenario 1: ticks at edges 4 and 8, seconds 1 then 2, no carry.
  task automatic test_count();
    logic [7:0] got, exp;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp = {(c % 4 == 0), 1'b0, 6'(c / 4)};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL count c=%0d {tick,alt,seg} got %h want %h", c, got, exp);
      end
    end
  endtask

  // Scenario 2: load 58, wrap 59->0 with a single carry.
  task automatic test_wrap();
    logic [7:0] got, exp;
    logic [5:0] s;
    set_i = 1'b1; set_val_i = 6'd58;
    step();
    set_i = 1'b0;
    got = {tick_o, alt_o, segundos_o};
    nvec++;
    if (got !== {2'b00, 6'd58}) begin
      nerr++;
      $display("FAIL wrap_load got %h want %h", got, {2'b00, 6'd58});
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      s   = (c < 4) ? 6'd58 : (c < 8) ? 6'd59 : 6'd0;
      exp = {(c == 4 || c == 8), (c == 8), s};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL wrap c=%0d {tick,alt,seg} got %h want %h", c, got, exp);
      end
    end
  endtask

  // Scenario 3: clamping of out-of-range loads; load works with en_i low.
  task automatic test_clamp();
    logic [5:0] vals [3] = '{6'd63, 6'd45, 6'd60};
    logic [5:0] exps [3] = '{6'd59, 6'd45, 6'd59};
    logic       ens  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      en_i = ens[i]; set_i = 1'b1; set_val_i = vals[i];
      step();
      set_i = 1'b0;
      exp = {2'b00, exps[i]};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL clamp val=%0d got %h want %h", vals[i], got, exp);
      end
    end
    en_i = 1'b1;
  endtask

  // Scenario 4: clr on the terminal edge at 59 discards tick and carry.
  task automatic test_clr_terminal();
    logic [7:0] got, exp;
    set_i = 1'b1; set_val_i = 6'd59;
    step();
    set_i = 1'b0;
    for (int c = 0; c < 3; c++) step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    got = {tick_o, alt_o, segundos_o};
    nvec++;
    if (got !== 8'h00) begin
      nerr++;
      $display("FAIL clr_on_terminal got %h want %h", got, 8'h00);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = {(c == 4), 1'b0, (c == 4) ? 6'd1 : 6'd0};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL clr_next c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  // Scenario 5: en_i low at phase 2 for 10 cycles freezes everything.
  task automatic test_enable_hold();
    logic [7:0] got, exp;
    step(); step();
    en_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== {2'b00, 6'd1}) begin
        nerr++;
        $display("FAIL hold c=%0d got %h want %h", c, got, {2'b00, 6'd1});
      end
    end
    en_i = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      step();
      exp = (c == 2) ? {2'b10, 6'd2} : {2'b00, 6'd1};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL resume c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  // Scenario 6: reset during the carry pulse clears outputs immediately.
  task automatic test_reset_mid_pulse();
    logic [7:0] got, exp;
    set_i = 1'b1; set_val_i = 6'd59;
    step();
    set_i = 1'b0;
    for (int c = 0; c < 4; c++) step();
    got = {tick_o, alt_o, segundos_o};
    nvec++;
    if (got !== 8'hC0) begin
      nerr++;
      $display("FAIL carry_before_reset got %h want %h", got, 8'hC0);
    end
    #2;
    rstn_i = 1'b0;
    #1;
    got = {tick_o, alt_o, segundos_o};
    nvec++;
    if (got !== 8'h00) begin
      nerr++;
      $display("FAIL async_reset got %h want %h", got, 8'h00);
    end
    #1;
    rstn_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = {(c == 4), 1'b0, (c == 4) ? 6'd1 : 6'd0};
      got = {tick_o, alt_o, segundos_o};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL restart c=%0d got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_clamp();
    test_clr_terminal();
    test_enable_hold();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/segundos.md
# segundos

Seconds stage of the clock datapath, directly upstream of the minutes counter. It divides the system clock down to a 1 Hz tick with an internal prescaler and counts seconds 0–59. On each 59→0 wrap it emits a one-cycle carry pulse, which drives the minutes counter's increment input. It also supports synchronous clear and load so the time-set logic can position the seconds value.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock cycles per second, i.e. the prescaler divide ratio. Must be ≥ 1. Simulation uses small values.

Ports:
- `clk_i`  in  1: system clock, rising edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `en_i`  in  1: run enable. Low freezes the prescaler and the seconds count.
- `clr_i`  in  1: synchronous clear of the seconds count and the prescaler.
- `set_i`  in  1: synchronous load of `set_val_i`.
- `set_val_i`  in  6: value to load, 0–59. Values above 59 are clamped to 59.
- `tick_o`  out  1: one-cycle pulse per elapsed second.
- `alt_o`  out  1: one-cycle carry pulse on the 59→0 wrap; feeds the minutes `inc_i`.
- `segundos_o`  out  6: current seconds, 0–59.

## Operation
- Reset (`rstn_i` low, asynchronous): prescaler = 0, `segundos_o` = 0, `tick_o` = 0, `alt_o` = 0. All outputs are registered.
- Prescaler: counter `pre_q` of width max(1, clog2(CLK_FREQ)).
  - When `en_i` = 1, it counts 0 … CLK_FREQ−1 and wraps.
  - A terminal condition occurs when `pre_q` == CLK_FREQ−1 and `en_i` = 1.
  - When CLK_FREQ = 1, every enabled cycle is terminal.
- Seconds counter, on a terminal condition:
  - If `segundos_o` == 59: next value is 0.
  - Otherwise: next value is `segundos_o` + 1.
  - Arithmetic is unsigned 6-bit. Values 60–63 are unreachable.
- Pulses:
  - `tick_o` = 1 for exactly the cycle after each terminal edge.
  - `alt_o` = 1 for exactly that cycle only if the count wrapped 59→0.
  - Both are 0 in every other cycle.
- Priority, evaluated per rising edge:
  - `clr_i` > `set_i` > terminal tick.
  - `clr_i`: `pre_q` = 0, `segundos_o` = 0, no `tick_o`/`alt_o`, regardless of `en_i`.
  - `set_i` (without `clr_i`): `pre_q` = 0, `segundos_o` = min(`set_val_i`, 59), no pulses, regardless of `en_i`.
  - A terminal tick coinciding with `clr_i` or `set_i` is discarded. No carry is produced even when the count was at 59.
- `en_i` deasserted mid-count: `pre_q` holds its value. Counting resumes from the same phase when `en_i` returns.
- Reset mid-pulse: `tick_o`/`alt_o` drop asynchronously with `rstn_i`.

## Timing
- Latency from the terminal edge to the `segundos_o` update and the `tick_o`/`alt_o` assertion: 0 cycles. All three are visible together in the cycle after the edge.
- With `en_i` held high, `tick_o` period = CLK_FREQ cycles, 1 cycle high. `alt_o` period = 60 × CLK_FREQ cycles.
- First `tick_o` after reset release with `en_i` = 1: CLK_FREQ edges later.
- `clr_i`/`set_i` take effect at the next rising edge. The next `tick_o` follows CLK_FREQ enabled edges after that.
- `alt_o` is a single-cycle pulse. The minutes stage's level latch clears it because `alt_o` returns low the following cycle. `alt_o` is never high for two consecutive cycles, even when CLK_FREQ = 1 (wraps are 60 cycles apart).

## Structure
- Shared package `relogio_pkg`:
  - `SEG_MAX` = 59, `SEG_W` = 6. The minutes and hours stages share these.
  - Also holds the `tempo_t` width typedef.
- Sub-module `prescaler`:
  - Parameter `DIV`; inputs `clk_i`, `rstn_i`, `en_i`, `sclr_i`; output `term_o`.
  - Reused by the blink/colon-flash logic.
- The top level holds the seconds register, the priority mux and the pulse registers.

## Test plan
All scenarios use CLK_FREQ = 4.
1. Reset release, `en_i` = 1, run 8 cycles → `tick_o` pulses at cycles 4 and 8; `segundos_o` = 1 then 2; `alt_o` stays 0.
2. `set_i` with `set_val_i` = 58, then run 8 enabled cycles → `segundos_o` 58→59→0; `alt_o` = 1 for exactly one cycle, coincident with `tick_o` and `segundos_o` = 0.
3. `set_val_i` = 63 with `set_i` → `segundos_o` = 59; no pulse. `set_val_i` = 45 → `segundos_o` = 45.
4. Count at 59 with `pre_q` = 3; assert `clr_i` on the terminal edge → `segundos_o` = 0, `alt_o` = 0, `tick_o` = 0. The next tick comes 4 cycles later.
5. Drop `en_i` at `pre_q` = 2 for 10 cycles → no pulses and `segundos_o` frozen. Restore `en_i` → `tick_o` after 2 edges.
6. Assert `rstn_i` low while `alt_o` = 1 (mid-cycle) → all outputs go to 0 immediately. After release, counting restarts from 0.
